// File: rtl/note_lane_scroller_if.sv
// note_lane_scroller_if: control, song ROM, hit and display signals of the note lane scroller
interface note_lane_scroller_if #(parameter int LANES = 2, DEPTH = 10, ADDR_W = 8);
  logic start, ack;
  logic [ADDR_W-1:0] song_len, rom_addr;
  logic [LANES-1:0] rom_data, hit;
  logic [LANES*DEPTH-1:0] note_map;
  logic [2:0] offset;
  logic [7:0] combo, max_combo;
  logic miss, busy, finish;
  modport master (output start, ack, song_len, rom_data, hit,
                  input rom_addr, note_map, offset, combo, max_combo, miss, busy, finish);
  modport slave (input start, ack, song_len, rom_data, hit,
                 output rom_addr, note_map, offset, combo, max_combo, miss, busy, finish);
endinterface

// File: rtl/note_lane_scroller.sv
// note_lane_scroller: scrolls a ROM-fed note chart down a window, judges hits and tracks combo
module note_lane_scroller #(
  parameter int LANES = 2,
  parameter int DEPTH = 10,
  parameter int TICK_DIV = 50000,
  parameter int SUBSTEPS = 7,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst,
  note_lane_scroller_if.slave io
);
  localparam int J = DEPTH - 2;
  localparam int NW = LANES * DEPTH;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, SCROLL, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, len_q, len_d;
  logic [NW-1:0] note_map_q, note_map_d, map_hit;
  logic [2:0] offset_q, offset_d;
  logic [7:0] combo_q, combo_d, max_combo_q, max_combo_d;
  logic miss_q, miss_d, busy_q, busy_d, finish_q, finish_d;
  logic run, tick, shift, lost;
  logic [LANES-1:0] match;
  logic [8:0] sum;
  always_comb begin
    run = state_q == SCROLL || state_q == DRAIN;
    tick = run && cnt_q == TW'(TICK_DIV - 1);
    shift = tick && offset_q == 3'(SUBSTEPS - 1);
    match = run ? io.hit & note_map_q[J*LANES +: LANES] : '0;
    map_hit = note_map_q & ~(NW'(match) << (J * LANES));
    // judged on the pre-shift window, so a note hit on the shift edge never counts as a miss
    lost = shift && |note_map_q[NW-1 -: LANES];
    sum = (lost ? 9'd0 : {1'b0, combo_q}) + 9'($countones(match));
    state_d = state_q;
    len_d = len_q;
    drain_d = drain_q;
    rom_addr_d = rom_addr_q;
    cnt_d = run ? (tick ? '0 : cnt_q + 1'b1) : '0;
    offset_d = tick ? (shift ? 3'd0 : offset_q + 3'd1) : offset_q;
    note_map_d = shift ? {map_hit[NW-LANES-1:0], state_q == SCROLL ? io.rom_data : LANES'(0)} : map_hit;
    combo_d = run ? (sum[8] ? 8'hff : sum[7:0]) : combo_q;
    max_combo_d = combo_d > max_combo_q ? combo_d : max_combo_q;
    miss_d = lost;
    if (state_q == IDLE && io.start) begin
      state_d = io.song_len == '0 ? DRAIN : SCROLL;
      len_d = io.song_len;
      drain_d = '0;
      rom_addr_d = '0;
      offset_d = '0;
      note_map_d = '0;
      combo_d = '0;
      max_combo_d = '0;
    end
    if (shift && state_q == SCROLL) begin
      rom_addr_d = rom_addr_q + 1'b1;
      state_d = rom_addr_q == len_q - 1'b1 ? DRAIN : SCROLL;
    end
    if (shift && state_q == DRAIN) begin
      drain_d = drain_q + 1'b1;
      state_d = drain_q == DW'(DEPTH - 1) ? DONE : DRAIN;
    end
    if (state_q == DONE && io.ack) state_d = IDLE;
    busy_d = state_d == SCROLL || state_d == DRAIN;
    finish_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      drain_q <= '0;
      rom_addr_q <= '0;
      len_q <= '0;
      note_map_q <= '0;
      offset_q <= '0;
      combo_q <= '0;
      max_combo_q <= '0;
      miss_q <= 1'b0;
      busy_q <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      drain_q <= drain_d;
      rom_addr_q <= rom_addr_d;
      len_q <= len_d;
      note_map_q <= note_map_d;
      offset_q <= offset_d;
      combo_q <= combo_d;
      max_combo_q <= max_combo_d;
      miss_q <= miss_d;
      busy_q <= busy_d;
      finish_q <= finish_d;
    end
  end
  assign io.rom_addr = rom_addr_q;
  assign io.note_map = note_map_q;
  assign io.offset = offset_q;
  assign io.combo = combo_q;
  assign io.max_combo = max_combo_q;
  assign io.miss = miss_q;
  assign io.busy = busy_q;
  assign io.finish = finish_q;
endmodule

// File: doc/note_lane_scroller.md
# note_lane_scroller

Parametrised successor to the two-colour note shifter in the LED-matrix rhythm game. It scrolls a LANES-wide note chart down a DEPTH-row window at a programmable speed, with sub-row pixel offset for smooth motion. Note rows are fetched from an external synchronous song ROM. The block judges per-lane hit pulses at a fixed judge row, tracks combo, max combo and misses, and sits between the song ROM, the button debouncers and the LED-matrix renderer.

## Interface
- LANES, 2, number of note lanes (colours)
- DEPTH, 10, visible rows; must be ≥ 3
- TICK_DIV, 50000, clk cycles per sub-row step; must be ≥ 1
- SUBSTEPS, 7, sub-row steps per row shift; must be ≥ 2 and ≤ 8
- ADDR_W, 8, song ROM address width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; starts a song from IDLE
- ack  in  1  one-cycle pulse; returns from DONE to IDLE
- song_len  in  ADDR_W  number of chart rows; sampled on an accepted start
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  LANES  chart row at rom_addr; synchronous ROM, 1-cycle latency
- hit  in  LANES  per-lane debounced hit pulses
- note_map  out  LANES*DEPTH  window; bit r*LANES+l = row r (0 = top), lane l
- offset  out  3  current sub-row step, 0..SUBSTEPS-1
- combo  out  8  current combo, saturates at 255
- max_combo  out  8  best combo this song
- miss  out  1  one-cycle pulse on any miss
- busy  out  1  high in SCROLL or DRAIN
- finish  out  1  high in DONE

## Operation
- States: IDLE, SCROLL, DRAIN, DONE. Reset enters IDLE and sets every output and register to 0.
- IDLE: on start, the block clears note_map, index, combo, max_combo and offset, latches song_len, and sets rom_addr=0. It then enters SCROLL, or DRAIN if song_len==0.
- Tick counter: runs only in SCROLL and DRAIN. It counts 0..TICK_DIV-1 and is cleared on entry to SCROLL. A tick is asserted when the count equals TICK_DIV-1.
- On a tick, offset increments. On a tick with offset==SUBSTEPS-1, offset wraps to 0 and a row shift occurs.
- Row shift:
  - Row r moves to row r+1; the old row DEPTH-1 falls off.
  - Row 0 is loaded with rom_data in SCROLL, or with 0 in DRAIN.
  - In SCROLL: index++, rom_addr = index+1. When the load just made uses index song_len-1, the block enters DRAIN.
- DRAIN: after exactly DEPTH row shifts, the block enters DONE.
- DONE: finish=1 and note_map stays frozen. On ack, enter IDLE and clear finish. start is ignored outside IDLE.
- Judge row J = DEPTH-2.
  - A hit[l] pulse in SCROLL or DRAIN while note_map bit J,l = 1 clears that bit, increments combo (saturating at 255), and sets max_combo = max(max_combo, new combo).
  - A hit on an empty cell does nothing.
- Miss: on a row shift, if any bit set in row DEPTH-1 falls off, miss pulses for 1 cycle and combo is cleared to 0. max_combo is kept.
- Hits on several lanes in one cycle each count; combo += popcount, saturating.
- Hit coincident with a row shift: the judge acts on the pre-shift row J. A matched bit moves to row DEPTH-1 as 0. Misses are evaluated on the pre-shift row DEPTH-1.
- Hit and miss in the same cycle: the miss clear takes priority, then the hit increment applies, so combo = number of hits. max_combo is updated accordingly.
- rst mid-song aborts immediately to IDLE with all outputs 0.

## Timing
- Accepted start at edge 0: SCROLL from cycle 1, rom_addr=0 at cycle 1.
- Row shift k (k ≥ 1) occurs at the edge ending cycle TICK_DIV*SUBSTEPS*k. The new note_map is visible the next cycle.
- rom_data is sampled at the shift edge. The ROM has ≥ TICK_DIV*SUBSTEPS-1 cycles to respond, which is ≥ 1.
- Total song duration is (song_len+DEPTH)*TICK_DIV*SUBSTEPS cycles; finish rises on the following cycle.
- miss, combo and max_combo update on the cycle after the causing edge. Every output is registered.

## Test plan
- Bench parameters: LANES=2, DEPTH=4, TICK_DIV=2, SUBSTEPS=2, unless noted.
- Reset: assert rst mid-SCROLL -> note_map=0, combo=0, max_combo=0, offset=0, rom_addr=0, busy=0, finish=0 on the same cycle.
- Scroll: song_len=3, ROM={2'b01,2'b10,2'b11}, start at cycle 0 -> row 0 = 01 at cycle 5, row 0 = 10 / row 1 = 01 at cycle 9, rom_addr steps 0,1,2,3; offset toggles 0/1 every 2 cycles.
- Hit: same song, pulse hit=2'b01 while row 2 holds 01 -> that bit clears, combo=1, max_combo=1. A hit on an empty cell leaves combo unchanged.
- Miss: hit lane 0 (combo=1), then let the lane-1 note fall off -> miss=1 for one cycle, combo=0, max_combo=1.
- End: song_len=3 -> 7 row shifts; finish=1 from cycle 29, busy=0. Start in DONE is ignored; ack -> IDLE. song_len=0 -> DONE after 4 shifts (cycle 17).
- Saturation and simultaneous events:
  - Hit+shift on the same edge -> the matched note does not miss.
  - Both lanes hit in one cycle -> combo += 2.
  - Combo preset near 255 -> combo holds at 255.
